// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the byte-serial command initiator: opcodes, FSM states
// and the opcode table (argument and response byte counts).
package serial_cmd_pkg;

  localparam logic [7:0] CMD_VERSION  = 8'd0;
  localparam logic [7:0] CMD_SET_DEAD = 8'd1;
  localparam logic [7:0] CMD_SET_FIRE = 8'd2;
  localparam logic [7:0] CMD_HISTO    = 8'd10;
  localparam logic [7:0] CMD_DELAY    = 8'd11;

  localparam int unsigned HIST_BYTES = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    SEND_WAIT,
    RECV
  } state_e;

  function automatic logic cmd_nargs(input logic [7:0] opcode);
    return (opcode == CMD_SET_DEAD) || (opcode == CMD_SET_FIRE);
  endfunction

  function automatic logic [5:0] cmd_nresp(input logic [7:0] opcode);
    case (opcode)
      CMD_VERSION, CMD_DELAY: return 6'd1;
      CMD_HISTO:              return 6'(HIST_BYTES);
      default:                return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmd_master.sv
// Host-side command initiator: sends opcode/argument bytes to a UART transmitter,
// collects the response bytes with a per-byte timeout and rebuilds histogram words.
module serial_cmd_master
  import serial_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES     = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_opcode,
  input  logic [7:0]   cmd_arg,
  input  logic         txBusy,
  output logic         txStart,
  output logic [7:0]   txData,
  input  logic         rxReady,
  input  logic [7:0]   rxData,
  output logic         resp_valid,
  output logic [7:0]   resp_data,
  output logic [4:0]   resp_index,
  output logic         hist_valid,
  output logic [255:0] hist_words,
  output logic         done,
  output logic         timeout_err
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 2);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CYCLES);

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [7:0]           arg_q, arg_d;
  logic                 nargs_q, nargs_d;
  logic [5:0]           nresp_q, nresp_d;
  logic                 ptr_q, ptr_d;
  logic [5:0]           count_q, count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [7:0]           resp_data_q, resp_data_d;
  logic [4:0]           resp_index_q, resp_index_d;
  logic                 hist_valid_q, hist_valid_d;
  logic [255:0]         hist_words_q, hist_words_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [255:0]         hist_buf_q, hist_merged;
  logic                 hist_wr;
  logic                 ready_c, tx_start_c, done_now_c;
  logic [7:0]           tx_data_c;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      arg_q        <= '0;
      nargs_q      <= 1'b0;
      nresp_q      <= '0;
      ptr_q        <= 1'b0;
      count_q      <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_index_q <= '0;
      hist_valid_q <= 1'b0;
      hist_words_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      arg_q        <= arg_d;
      nargs_q      <= nargs_d;
      nresp_q      <= nresp_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_index_q <= resp_index_d;
      hist_valid_q <= hist_valid_d;
      hist_words_q <= hist_words_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  // NOTE: the staging buffer is only published after a full histogram, so it needs no reset.
  always_ff @(posedge clk) begin
    if (hist_wr) hist_buf_q <= hist_merged;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    arg_d        = arg_q;
    nargs_d      = nargs_q;
    nresp_d      = nresp_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_index_d = resp_index_q;
    hist_valid_d = 1'b0;
    hist_words_d = hist_words_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    hist_merged  = hist_buf_q;
    hist_merged[{count_q[4:0], 3'b000} +: 8] = rxData;
    hist_wr      = 1'b0;
    ready_c      = 1'b0;
    tx_start_c   = 1'b0;
    tx_data_c    = '0;
    done_now_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_c = (gap_q == '0);
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        if (cmd_valid && ready_c) begin
          opcode_d = cmd_opcode;
          arg_d    = cmd_arg;
          nargs_d  = cmd_nargs(cmd_opcode);
          nresp_d  = cmd_nresp(cmd_opcode);
          ptr_d    = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        tx_data_c = ptr_q ? arg_q : opcode_q;
        if (!txBusy) begin
          tx_start_c = 1'b1;
          state_d    = SEND_WAIT;
        end
      end
      SEND_WAIT: begin
        if (ptr_q < nargs_q) begin
          ptr_d   = 1'b1;
          state_d = SEND;
        end else if (nresp_q == '0) begin
          done_now_c = 1'b1;
          gap_d      = GAP_LOAD;
          state_d    = IDLE;
        end else begin
          count_d = '0;
          timer_d = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        // A byte arriving on the expiry cycle still counts and restarts the timer.
        if (rxReady) begin
          resp_valid_d = 1'b1;
          resp_data_d  = rxData;
          resp_index_d = count_q[4:0];
          count_d      = count_q + 6'd1;
          timer_d      = '0;
          hist_wr      = (opcode_q == CMD_HISTO);
          if (count_q + 6'd1 == nresp_q) begin
            done_d  = 1'b1;
            gap_d   = GAP_LOAD;
            state_d = IDLE;
            if (opcode_q == CMD_HISTO) begin
              hist_valid_d = 1'b1;
              hist_words_d = hist_merged;
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          gap_d     = GAP_LOAD;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = ready_c & ~reset;
  assign txStart     = tx_start_c & ~reset;
  assign txData      = reset ? 8'h00 : tx_data_c;
  assign done        = done_q | (done_now_c & ~reset);
  assign timeout_err = timeout_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_index  = resp_index_q;
  assign hist_valid  = hist_valid_q;
  assign hist_words  = hist_words_q;

endmodule

// File: tb/tb_serial_cmd_master.sv
// Self-checking bench: directed protocol scenarios plus randomized commands,
// scored against a transaction-level model of the command protocol.
module tb_serial_cmd_master;

  localparam int TO  = 100;
  localparam int GAP = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   cmd_opcode = 8'h00;
  logic [7:0]   cmd_arg = 8'h00;
  logic         txBusy = 1'b0;
  logic         txStart;
  logic [7:0]   txData;
  logic         rxReady = 1'b0;
  logic [7:0]   rxData = 8'h00;
  logic         resp_valid;
  logic [7:0]   resp_data;
  logic [4:0]   resp_index;
  logic         hist_valid;
  logic [255:0] hist_words;
  logic         done;
  logic         timeout_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_cmd_master #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg),
    .txBusy(txBusy), .txStart(txStart), .txData(txData),
    .rxReady(rxReady), .rxData(rxData),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_index(resp_index),
    .hist_valid(hist_valid), .hist_words(hist_words),
    .done(done), .timeout_err(timeout_err)
  );

  // Event log, sampled mid-cycle.
  int st_cyc[$], st_dat[$], rv_cyc[$], rv_dat[$], rv_idx[$];
  int dn_cyc[$], dn_to[$], hv_cyc[$], rdy_cyc[$];
  int busy_viol = 0, consec_viol = 0, orphan_to = 0, orphan_hv = 0;
  bit prev_start = 1'b0, prev_ready = 1'b0;

  always @(negedge clk) begin
    if (txStart) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(int'(txData));
      if (txBusy) busy_viol++;
      if (prev_start) consec_viol++;
    end
    prev_start = txStart;
    if (resp_valid) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(int'(resp_data));
      rv_idx.push_back(int'(resp_index));
    end
    if (done) begin
      dn_cyc.push_back(cyc);
      dn_to.push_back(int'(timeout_err));
    end
    if (timeout_err && !done) orphan_to++;
    if (hist_valid) begin
      hv_cyc.push_back(cyc);
      if (!done) orphan_hv++;
    end
    if (cmd_ready && !prev_ready) rdy_cyc.push_back(cyc);
    prev_ready = cmd_ready;
  end

  // UART transmitter model: busy for busy_len cycles starting the cycle after a start.
  int handled = 0, busy_left = 0, busy_len = 0;
  always begin
    @(posedge clk);
    #1;
    if (st_cyc.size() != handled) begin
      handled   = st_cyc.size();
      busy_left = busy_len;
    end
    txBusy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_nargs(input logic [7:0] op);
    return (op == 8'd1 || op == 8'd2) ? 1 : 0;
  endfunction

  function automatic int ref_nresp(input logic [7:0] op);
    if (op == 8'd0 || op == 8'd11) return 1;
    if (op == 8'd10) return 32;
    return 0;
  endfunction

  logic [255:0] exp_hist = '0;
  int           busy_free = 0;
  logic [7:0]   rx_plan [40];
  int           rx_log[$];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 256'(cmd_ready), 256'(0));
    check({tag, "_txStart"}, 256'(txStart), 256'(0));
    check({tag, "_txData"}, 256'(txData), 256'(0));
    check({tag, "_resp_valid"}, 256'(resp_valid), 256'(0));
    check({tag, "_resp_data"}, 256'(resp_data), 256'(0));
    check({tag, "_resp_index"}, 256'(resp_index), 256'(0));
    check({tag, "_hist_valid"}, 256'(hist_valid), 256'(0));
    check({tag, "_hist_words"}, hist_words, 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_timeout_err"}, 256'(timeout_err), 256'(0));
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 2000) begin
      tick();
      w++;
    end
    check("ready_before_cmd", 256'(cmd_ready), 256'(1));
  endtask

  // One full command: accept, remote side, then score against the model.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] arg, input int bl,
                         input int nsend, input int first_delay, input int gap_max);
    int s0, r0, d0, h0, rd0, ntx, nresp, acc, lst, refc, cnt, exp_done, exp_to, w;
    int first_exp, exp_hv;
    bit fin;
    int e_dat[$], e_idx[$], e_cyc[$];
    ntx   = 1 + ref_nargs(op);
    nresp = ref_nresp(op);
    busy_len = bl;
    wait_ready();
    s0 = st_cyc.size(); r0 = rv_cyc.size(); d0 = dn_cyc.size(); h0 = hv_cyc.size();
    rx_log.delete();
    cmd_valid = 1'b1; cmd_opcode = op; cmd_arg = arg; acc = cyc;
    tick();
    cmd_valid = 1'b0; cmd_opcode = 8'($urandom); cmd_arg = 8'($urandom);
    rd0 = rdy_cyc.size();
    fork
      begin : remote
        int wr = 0;
        while (st_cyc.size() - s0 < ntx && wr < 3000) begin
          tick();
          wr++;
        end
        if (st_cyc.size() - s0 >= ntx) begin
          while (cyc < st_cyc[s0 + ntx - 1] + first_delay) tick();
          for (int i = 0; i < nsend; i++) begin
            rxReady = 1'b1;
            rxData  = rx_plan[i];
            rx_log.push_back(cyc);
            tick();
            rxReady = 1'b0;
            repeat ($urandom_range(gap_max, 0)) tick();
          end
        end
      end
      begin : waiter
        int wd = 0;
        while (dn_cyc.size() == d0 && wd < 5000) begin
          tick();
          wd++;
        end
      end
    join
    w = 0;
    while (rdy_cyc.size() == rd0 && w < 3000) begin
      tick();
      w++;
    end

    check("tx_count", 256'(st_cyc.size() - s0), 256'(ntx));
    if (st_cyc.size() - s0 < ntx) return;
    check("tx_opcode", 256'(st_dat[s0]), 256'(op));
    first_exp = (acc + 1 > busy_free) ? acc + 1 : busy_free;
    check("tx_first_cycle", 256'(st_cyc[s0]), 256'(first_exp));
    if (ntx == 2) begin
      check("tx_arg", 256'(st_dat[s0 + 1]), 256'(arg));
      check("tx_second_cycle", 256'(st_cyc[s0 + 1]), 256'(st_cyc[s0] + ((bl + 1 > 2) ? bl + 1 : 2)));
    end
    lst = st_cyc[s0 + ntx - 1];
    busy_free = lst + bl + 1;

    // Model: bytes count while each arrives within TO cycles of the previous reference point.
    exp_to = 0;
    if (nresp == 0) begin
      exp_done = lst + 1;
    end else begin
      refc = lst + 2; cnt = 0; fin = 1'b0; exp_done = 0;
      foreach (rx_log[i]) begin
        if (!fin) begin
          if (rx_log[i] > refc + TO - 1) begin
            exp_done = refc + TO; exp_to = 1; fin = 1'b1;
          end else begin
            e_dat.push_back(int'(rx_plan[i])); e_idx.push_back(cnt); e_cyc.push_back(rx_log[i] + 1);
            cnt++;
            refc = rx_log[i] + 1;
            if (cnt == nresp) begin
              exp_done = rx_log[i] + 1; fin = 1'b1;
            end
          end
        end
      end
      if (!fin) begin
        exp_done = refc + TO; exp_to = 1;
      end
    end

    check("resp_count", 256'(rv_cyc.size() - r0), 256'(e_dat.size()));
    for (int i = 0; i < e_dat.size() && r0 + i < rv_cyc.size(); i++) begin
      check("resp_data", 256'(rv_dat[r0 + i]), 256'(e_dat[i]));
      check("resp_index", 256'(rv_idx[r0 + i]), 256'(e_idx[i]));
      check("resp_cycle", 256'(rv_cyc[r0 + i]), 256'(e_cyc[i]));
    end
    check("done_count", 256'(dn_cyc.size() - d0), 256'(1));
    if (dn_cyc.size() > d0) begin
      check("done_cycle", 256'(dn_cyc[d0]), 256'(exp_done));
      check("timeout_err", 256'(dn_to[d0]), 256'(exp_to));
    end
    exp_hv = (op == 8'd10 && exp_to == 0) ? 1 : 0;
    check("hist_valid_count", 256'(hv_cyc.size() - h0), 256'(exp_hv));
    if (exp_hv == 1) begin
      if (hv_cyc.size() > h0) check("hist_valid_cycle", 256'(hv_cyc[h0]), 256'(exp_done));
      for (int i = 0; i < 32; i++) exp_hist[32 * (i / 4) + 8 * (i % 4) +: 8] = 8'(e_dat[i]);
    end
    check("hist_words", hist_words, exp_hist);
    check("ready_rise_seen", 256'(rdy_cyc.size() > rd0), 256'(1));
    if (rdy_cyc.size() > rd0)
      check("ready_after_gap", 256'(rdy_cyc[rd0]), 256'(exp_done + GAP + ((nresp == 0) ? 1 : 0)));
  endtask

  // Abort a histogram read part-way through with reset.
  task automatic reset_mid_histo();
    int s0, r0, d0, w;
    busy_len = 0;
    wait_ready();
    s0 = st_cyc.size(); r0 = rv_cyc.size(); d0 = dn_cyc.size();
    cmd_valid = 1'b1; cmd_opcode = 8'd10; cmd_arg = 8'h00;
    tick();
    cmd_valid = 1'b0;
    w = 0;
    while (st_cyc.size() == s0 && w < 100) begin
      tick();
      w++;
    end
    check("rst_tx_seen", 256'(st_cyc.size() - s0), 256'(1));
    while (cyc < st_cyc[st_cyc.size() - 1] + 3) tick();
    for (int i = 0; i < 5; i++) begin
      rxReady = 1'b1; rxData = 8'($urandom);
      tick();
    end
    rxReady = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_partial_resp", 256'(rv_cyc.size() - r0), 256'(5));
    check_reset_outputs("rst_mid");
    tick();
    reset = 1'b0;
    #1;
    check("rst_ready_after", 256'(cmd_ready), 256'(1));
    repeat (TO + 20) tick();
    check("rst_no_done", 256'(dn_cyc.size() - d0), 256'(0));
    exp_hist  = '0;
    busy_free = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, nr, mode, ns;
    reset = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    tick();
    reset = 1'b0;
    #1;
    check("ready_after_reset", 256'(cmd_ready), 256'(1));

    // Version read, reply lands on the last cycle before expiry.
    rx_plan[0] = 8'h02;
    run_cmd(8'd0, 8'h00, 0, 1, 2 + TO - 1, 0);
    // Argument command against a slow transmitter.
    run_cmd(8'd1, 8'h0A, 20, 0, 2, 0);
    // Full histogram with a known byte ramp.
    for (int i = 0; i < 40; i++) rx_plan[i] = 8'(i);
    run_cmd(8'd10, 8'h00, 0, 32, 3, 2);
    check("hist_word0", 256'(hist_words[31:0]), 256'(32'h03020100));
    check("hist_word7", 256'(hist_words[255:224]), 256'(32'h1F1E1D1C));
    // Delay read with no reply, then with a reply one cycle too late.
    run_cmd(8'd11, 8'h00, 0, 0, 2, 0);
    rx_plan[0] = 8'h5A;
    run_cmd(8'd11, 8'h00, 0, 1, 2 + TO, 0);
    // Reset during a histogram read, then a normal version read.
    reset_mid_histo();
    rx_plan[0] = 8'h02;
    run_cmd(8'd0, 8'h00, 0, 1, 5, 0);

    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 15);
      if (op == 15) op = $urandom_range(13, 255);
      for (int i = 0; i < 40; i++) rx_plan[i] = 8'($urandom);
      nr = ref_nresp(8'(op));
      mode = $urandom_range(0, 3);
      if (nr == 0) ns = 0;
      else if (mode == 0) ns = $urandom_range(nr - 1, 0);
      else if (mode == 1) ns = nr + 1;
      else ns = nr;
      run_cmd(8'(op), 8'($urandom), $urandom_range(0, 6), ns, $urandom_range(2, 12), $urandom_range(0, 4));
    end

    check("txstart_while_busy", 256'(busy_viol), 256'(0));
    check("txstart_back_to_back", 256'(consec_viol), 256'(0));
    check("timeout_without_done", 256'(orphan_to), 256'(0));
    check("hist_valid_without_done", 256'(orphan_hv), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
